// File: rtl/instr_decode_stage_pkg.sv
// Shared MIPS instruction constants: class codes, opcode/funct values, decoded-entry struct.
package instr_decode_stage_pkg;

    typedef enum logic [3:0] {
        CLS_ADDU    = 4'd0,
        CLS_SUBU    = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_LUI     = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_SLL     = 4'd9,
        CLS_UNKNOWN = 4'hF
    } instr_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        instr_cls_e  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] jaddr;
    } dec_t;

    localparam dec_t DEC_RST = '{cls: CLS_UNKNOWN, default: '0};

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and control-side handshake bundle for the decode stage.
// out_illegal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface instr_decode_stage_if;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_instr;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [15:0] out_imm16;
    logic [25:0] out_jaddr;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        out_illegal;
`endif

    modport slave (
        input  in_valid, in_word, flush, out_ready,
        output in_ready, out_valid, out_instr, out_rs, out_rt, out_rd,
               out_shamt, out_imm16, out_jaddr
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output out_illegal
`endif
    );

    modport master (
        output in_valid, in_word, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_rs, out_rt, out_rd,
               out_shamt, out_imm16, out_jaddr
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input out_illegal
`endif
    );
endinterface

// File: rtl/instr_decode_stage_classify.sv
// Combinational map from a MIPS word to its instruction class code.
module instr_classify
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0] word,
    output instr_cls_e  cls
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_mid;

    assign op         = word[31:26];
    assign funct      = word[5:0];
    assign unused_mid = ^word[25:6];

    always_comb begin
        cls = CLS_UNKNOWN;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CLS_ADDU;
                    FN_SUBU: cls = CLS_SUBU;
                    FN_SLL:  cls = CLS_SLL;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_UNKNOWN;
                endcase
            end
            OP_ORI:  cls = CLS_ORI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_LUI:  cls = CLS_LUI;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_UNKNOWN;
        endcase
    end
endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: classify + field split at input, 2-entry (main + skid) output buffer.
// Define DECODE_ILLEGAL_TRAP_EN to drop UNKNOWN words and raise a sticky out_illegal.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    instr_decode_stage_if.slave   bus
);
    instr_cls_e cls;
    dec_t       in_dec;
    dec_t       main_q, main_d, skid_q, skid_d;
    logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop, enq;

    instr_classify u_classify (.word(bus.in_word), .cls(cls));

    always_comb begin
        in_dec       = DEC_RST;
        in_dec.cls   = cls;
        in_dec.rs    = bus.in_word[25:21];
        in_dec.rt    = bus.in_word[20:16];
        in_dec.rd    = bus.in_word[15:11];
        in_dec.shamt = bus.in_word[10:6];
        in_dec.imm16 = bus.in_word[15:0];
        in_dec.jaddr = bus.in_word[25:0];
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = main_vld_q && bus.out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    // UNKNOWN words still handshake on input but never reach the buffer.
    assign enq       = push && (cls != CLS_UNKNOWN);
    assign illegal_d = illegal_q || (push && !bus.flush && (cls == CLS_UNKNOWN));
    assign bus.out_illegal = illegal_q;

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
`else
    assign enq = push;
`endif

    // Skid only fills when main is stalled; it is always empty while main is empty.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (enq) begin
                main_d     = in_dec;
                main_vld_d = 1'b1;
            end
        end else if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (pop) begin
            main_d     = in_dec;
            main_vld_d = enq;
        end else if (enq) begin
            skid_d     = in_dec;
            skid_vld_d = 1'b1;
        end
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= DEC_RST;
            skid_q     <= DEC_RST;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_vld_q;
    assign bus.out_instr = main_q.cls;
    assign bus.out_rs    = main_q.rs;
    assign bus.out_rt    = main_q.rt;
    assign bus.out_rd    = main_q.rd;
    assign bus.out_shamt = main_q.shamt;
    assign bus.out_imm16 = main_q.imm16;
    assign bus.out_jaddr = main_q.jaddr;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage; inputs change and outputs are checked #1 after posedge.
module tb_instr_decode_stage;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    instr_decode_stage_if bus ();
    instr_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 4'hF) begin n_bad++; $display("FAIL rst_instr got %h want f", bus.out_instr); end
        n_cmp++; if ({bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_imm16, bus.out_jaddr} !== 62'd0)
            begin n_bad++; $display("FAIL rst_fields got nonzero want 0"); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal got %0b want 0", bus.out_illegal); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_addu();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h00221821;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL addu_valid got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 4'd0) begin n_bad++; $display("FAIL addu_instr got %h want 0", bus.out_instr); end
        n_cmp++; if ({bus.out_rs, bus.out_rt, bus.out_rd} !== {5'd1, 5'd2, 5'd3})
            begin n_bad++; $display("FAIL addu_regs got %0d/%0d/%0d want 1/2/3", bus.out_rs, bus.out_rt, bus.out_rd); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL addu_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_ori_jal();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h342300FF;
        step();
        n_cmp++; if (bus.out_instr !== 4'd2 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ori_instr got %h want 2", bus.out_instr); end
        n_cmp++; if ({bus.out_rs, bus.out_rt, bus.out_imm16} !== {5'd1, 5'd3, 16'h00FF})
            begin n_bad++; $display("FAIL ori_fields got %0d/%0d/%h want 1/3/00ff", bus.out_rs, bus.out_rt, bus.out_imm16); end
        bus.in_word = 32'h0C000010;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_instr !== 4'd7 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL jal_instr got %h want 7", bus.out_instr); end
        n_cmp++; if (bus.out_jaddr !== 26'h0000010) begin n_bad++; $display("FAIL jal_jaddr got %h want 0000010", bus.out_jaddr); end
        step();
    endtask

    task automatic test_classes();
        logic [31:0] words [8];
        logic [3:0]  clsx  [8];
        words = '{32'h00221823, 32'h00021080, 32'h03E00008, 32'h8C220004,
                  32'hAC220004, 32'h10220003, 32'h3C011234, 32'h00000001};
        clsx  = '{4'd1, 4'd9, 4'd8, 4'd3, 4'd4, 4'd5, 4'd6, 4'hF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (clsx[i] == 4'hF) continue;
`endif
            bus.in_valid = 1'b1;
            bus.in_word  = words[i];
            step();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== clsx[i])
                begin n_bad++; $display("FAIL class_%0d got %h want %h", i, bus.out_instr, clsx[i]); end
        end
        bus.in_valid = 1'b0;
        // SLL 0x00021080: rt=2 rd=2 shamt=2 ; LUI 0x3C011234: rt=1 imm=1234 (last checked above is LUI or UNKNOWN)
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h00021080;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.out_rt, bus.out_rd, bus.out_shamt} !== {5'd2, 5'd2, 5'd2})
            begin n_bad++; $display("FAIL sll_fields got %0d/%0d/%0d want 2/2/2", bus.out_rt, bus.out_rd, bus.out_shamt); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h00221821;   // A: ADDU rd=3
        step();
        bus.in_word   = 32'h00853023;   // B: SUBU rs=4 rt=5 rd=6
        step();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %0b want 0", bus.in_ready); end
        bus.in_word   = 32'h342300FF;   // C: offered while full, must be ignored
        step();
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 4'd0 || bus.out_rd !== 5'd3)
            begin n_bad++; $display("FAIL bp_hold got rdy=%0b instr=%h rd=%0d want 0/0/3", bus.in_ready, bus.out_instr, bus.out_rd); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 4'd1 || bus.out_rd !== 5'd6 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_second got v=%0b instr=%h rd=%0d rdy=%0b want 1/1/6/1", bus.out_valid, bus.out_instr, bus.out_rd, bus.in_ready); end
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h342300FF;
        step();
        bus.in_valid  = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 4'd2)
            begin n_bad++; $display("FAIL bp_third got v=%0b instr=%h want 1/2", bus.out_valid, bus.out_instr); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h00221821;
        step();
        bus.in_word   = 32'h00853023;
        step();
        bus.flush     = 1'b1;
        bus.in_word   = 32'h342300FF;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL flush_full got v=%0b rdy=%0b want 0/1", bus.out_valid, bus.in_ready); end
        bus.flush     = 1'b0;
        bus.in_word   = 32'h00221821;
        step();
        bus.flush     = 1'b1;
        bus.in_word   = 32'h0C000010;   // accepted-looking push during flush must vanish
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_bad++; $display("FAIL flush_push got v=%0b rdy=%0b want 0/1", bus.out_valid, bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_leak got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_unknown();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'hFC000000;
        step();
        bus.in_valid  = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_illegal !== 1'b1)
            begin n_bad++; $display("FAIL unk_trap got v=%0b ill=%0b want 0/1", bus.out_valid, bus.out_illegal); end
        step();
        step();
        n_cmp++; if (bus.out_illegal !== 1'b1) begin n_bad++; $display("FAIL unk_sticky got %0b want 1", bus.out_illegal); end
`else
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 4'hF)
            begin n_bad++; $display("FAIL unk_pass got v=%0b instr=%h want 1/f", bus.out_valid, bus.out_instr); end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 32'h00221821;
        step();
        bus.in_word   = 32'h00853023;
        step();
        reset = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 4'hF || bus.in_ready !== 1'b1 || bus.out_rd !== 5'd0)
            begin n_bad++; $display("FAIL rstmid got v=%0b instr=%h rdy=%0b rd=%0d want 0/f/1/0", bus.out_valid, bus.out_instr, bus.in_ready, bus.out_rd); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        n_cmp++; if (bus.out_illegal !== 1'b0) begin n_bad++; $display("FAIL rstmid_ill got %0b want 0", bus.out_illegal); end
`endif
        reset = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_word   = 32'h342300FF;
        step();
        bus.in_valid  = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 4'd2 || bus.out_imm16 !== 16'h00FF)
            begin n_bad++; $display("FAIL rstmid_resume got v=%0b instr=%h imm=%h want 1/2/00ff", bus.out_valid, bus.out_instr, bus.out_imm16); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_drain got %0b want 0", bus.out_valid); end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_addu();
        test_ori_jal();
        test_classes();
        test_backpressure();
        test_flush();
        test_unknown();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high.
REQ-003 SHALL have in_valid, input, 1, and in_word, input, 32, the fetched MIPS instruction word.
REQ-004 SHALL have in_ready, output, 1, indicating the stage accepts a word this cycle.
REQ-005 SHALL have flush, input, 1, discarding all buffered entries.
REQ-006 SHALL have out_valid, output, 1, and out_ready, input, 1, as the downstream handshake.
REQ-007 SHALL have out_instr, output, 4, the instruction class code consumed by the control decoder.
REQ-008 SHALL have out_rs, out_rt, out_rd, out_shamt (each 5), out_imm16 (16), and out_jaddr (26) as outputs.
REQ-009 SHALL have out_illegal, output, 1, which exists only under DECODE_ILLEGAL_TRAP_EN.

Function
REQ-010 SHALL map words to class codes: op 0x00 with funct 0x21 -> ADDU; op 0x00 with funct 0x23 -> SUBU; op 0x00 with funct 0x00 -> SLL; op 0x00 with funct 0x08 -> JR.
REQ-011 SHALL map op 0x0D -> ORI, op 0x23 -> LW, op 0x2B -> SW, op 0x04 -> BEQ, op 0x0F -> LUI, op 0x03 -> JAL, and every other word -> UNKNOWN (4'hF).
REQ-012 SHALL extract fields as rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], imm16=[15:0], jaddr=[25:0], without extension.
REQ-013 SHALL decode combinationally at input and register the result, giving a latency of exactly 1 cycle from the in_valid&&in_ready edge to out_valid.
REQ-014 SHALL buffer in a 2-entry skid (main + skid), with in_ready a registered signal equal to !skid_full.
REQ-015 SHALL sustain one word per cycle when out_ready is held high.
REQ-016 SHALL, when out_valid&&!out_ready, hold all out_* stable until accepted, and SHALL capture an arriving word into skid.
REQ-017 SHALL refill main from skid on acceptance and reopen in_ready on the next cycle; entries leave in arrival order.
REQ-018 SHALL accept no word while both entries are full (in_ready=0); in_valid in that state is ignored.
REQ-019 SHALL give flush priority over all else: both entries invalidated next cycle, a simultaneous in_valid word dropped, and in_ready=1 next cycle.
REQ-020 SHALL allow a simultaneous push and pop to preserve occupancy.

Reset
REQ-021 SHALL, when reset is asserted, clear both entries next edge: out_valid=0, in_ready=1, out_instr=4'hF, all field outputs 0, out_illegal=0.
REQ-022 SHALL let reset override flush and handshakes, and SHALL discard any mid-stream entries.

Configuration
REQ-023 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, make out_illegal a sticky register set in the cycle an UNKNOWN word is accepted and cleared only by reset.
REQ-024 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, drop UNKNOWN words (not enqueued) while still handshaking them on input.
REQ-025 SHALL, without DECODE_ILLEGAL_TRAP_EN, omit the port and enqueue UNKNOWN words normally with out_instr=4'hF.

Structure
REQ-026 SHALL place the class-code constants (ADDU=0, SUBU=1, ORI=2, LW=3, SW=4, BEQ=5, LUI=6, JAL=7, JR=8, SLL=9, UNKNOWN=15) and the opcode/funct constants in the shared instr package, used by this block and the control decoder.
REQ-027 SHALL place the combinational map in one sub-module, instr_classify (word in, class code out); buffering stays in the top module.

Verification
REQ-028 SHALL cover: in_word 0x00221821 with out_ready=1 -> next cycle out_instr=ADDU, rs=1, rt=2, rd=3.
REQ-029 SHALL cover: 0x342300FF -> ORI, rs=1, rt=3, imm16=0x00FF; then 0x0C000010 -> JAL, jaddr=0x0000010.
REQ-030 SHALL cover: out_ready=0 for 3 cycles while streaming -> two entries held, in_ready=0 by the third edge; after release, output order is preserved and no word is lost.
REQ-031 SHALL cover: flush together with in_valid while full -> next cycle out_valid=0, in_ready=1, and the dropped word is never output.
REQ-032 SHALL cover: 0xFC000000 -> with the macro, out_illegal=1 sticky and nothing output; without it, out_instr=4'hF.
REQ-033 SHALL cover: reset asserted mid-stream -> next cycle out_valid=0, out_instr=4'hF, and the stream resumes correctly afterward.
